shift_add_mult: RTL and testbench
=================================

# shift_add_mult

Sequential unsigned N×N multiplier that produces a 2N-bit product by shift-and-add, one multiplier bit per clock. It sits directly in front of the team's N-bit carry-lookahead adder (CLAD). Each cycle it drives the adder's operands with the running partial product and the multiplicand, then consumes the adder's sum and carry-out. One CLAD instance is reused for all N iterations, trading latency for area.

## Interface
- N, default 8: operand width in bits; N ≥ 2.

- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  reset, asynchronous assert, active-low. Deassertion is synchronised externally.
- start  input  1  request to begin; accepted only on a rising edge where in_ready=1.
- a  input  N  multiplicand, unsigned; sampled on the accepting edge.
- b  input  N  multiplier, unsigned; sampled on the accepting edge.
- in_ready  output  1  high in IDLE only.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle completion pulse.
- product  output  2N  registered result; held until the next completion.

## Operation
- Registers:
  - mcand[N-1:0], the multiplicand.
  - acc_hi[N-1:0], the upper partial product.
  - q[N-1:0], the multiplier, which becomes the lower product half.
  - cnt, a ceil(log2(N+1))-bit iteration counter.
  - state.
  - product.
  - done.
- Adder: one CLAD #(N) instance with A=acc_hi, B=mcand, giving sum and cout. Carry-in is fixed at 0.
- FSM states: IDLE, RUN, DONE.
- IDLE → RUN when start=1.
  - Load mcand←a, acc_hi←0, q←b, cnt←0.
- RUN, each edge:
  - If q[0]=1: {acc_hi,q} ← {cout, sum, q[N-1:1]}.
  - Else: {acc_hi,q} ← {1'b0, acc_hi, q[N-1:1]}.
  - cnt←cnt+1.
- RUN → DONE on the edge where cnt=N-1, which is the Nth iteration.
  - On that same edge, product ← the post-shift {acc_hi,q} and done←1.
- DONE → IDLE unconditionally on the next edge; done←0.
- start is ignored in RUN and DONE. There is no queueing and no error flag.
- Width rule: the maximum result (2^N-1)^2 < 2^(2N), so product never overflows. cout is the only carry and enters acc_hi[N-1] on the shift.
- a and b may change freely after the accepting edge; the internal copies are used.
- Reset, including mid-operation, forces:
  - state=IDLE
  - acc_hi, q, mcand, cnt, product = 0
  - done=0
  - The in-flight operation is discarded; no done pulse.

## Timing
- Reset values of outputs: in_ready=1, busy=0, done=0, product=0.
- Call the accepting edge E0.
- Iteration edges are E1..EN.
- done=1 and product valid during the cycle after EN, i.e. N edges after E0.
- DONE → IDLE at EN+1.
- in_ready returns high after EN+1.
- With start held high, the next accept is at EN+2, giving one result every N+2 cycles.
- busy rises after E0 and falls after EN+1.
- product changes only at the DONE-entry edge and at reset.
- There are no combinational paths from inputs to outputs; all outputs are registered or decoded from state.
- The critical path is one N-bit CLAD add plus the shift mux.

## Test plan
- Reset then idle, N=8:
  - Drive rst_n low mid-simulation.
  - Required: in_ready=1, busy=0, done=0, product=0x0000.
- Basic products, N=8:
  - a=13, b=11 → done exactly 8 edges after accept, product=0x008F.
  - a=0x00, b=0xA5 → 0x0000.
  - a=0xFF, b=0x01 → 0x00FF.
- Carry path, N=8:
  - a=0xFF, b=0xFF → product=0xFE01.
  - Check that the cout=1 iterations are exercised.
- Back-to-back with start held high:
  - Stimulus: 3×5, then 200×200.
  - Required: results 0x000F, then 0x9C40.
  - Accepts exactly 10 cycles apart.
  - The first product is held until the second done.
- Ignored start and operand changes:
  - Pulse start and change a/b during RUN and during DONE.
  - Required: the result equals the originally sampled operands; no extra done pulse.
- Reset mid-operation and random test:
  - Assert rst_n low after E4 of 0xAB×0xCD: no done pulse, product=0. The next operation 7×9 returns 0x003F.
  - Then run 1000 random operand pairs at N=8 and N=16 against a reference a*b.

Source files
------------

// File: rtl/shift_add_mult_if.sv
// shift_add_mult_if: start/operand request and result bundle for the shift-and-add multiplier
interface shift_add_mult_if #(parameter int N = 8);
  logic start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic in_ready;
  logic busy;
  logic done;
  logic [2*N-1:0] product;
  modport master(output start, a, b, input in_ready, busy, done, product);
  modport slave(input start, a, b, output in_ready, busy, done, product);
endinterface

// File: rtl/shift_add_mult.sv
// shift_add_mult: sequential unsigned NxN multiplier, one multiplier bit per clock through a shared CLAD
module clad #(parameter int N = 8) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);
  logic [N:0] c;
  // carry chain from per-bit generate/propagate terms
  always_comb begin
    c[0] = cin;
    for (int i = 0; i < N; i++) c[i+1] = (a[i] & b[i]) | ((a[i] ^ b[i]) & c[i]);
  end
  assign sum  = a ^ b ^ c[N-1:0];
  assign cout = c[N];
endmodule

module shift_add_mult #(parameter int N = 8) (
  input logic clk,
  input logic rst_n,
  shift_add_mult_if.slave bus
);
  localparam int CW = $clog2(N + 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [N-1:0] mcand, acc_hi, q, sum, nxt_hi, nxt_q;
  logic [CW-1:0] cnt;
  logic [2*N-1:0] product;
  logic cout, done, last;
  clad #(.N(N)) u_clad (.a(acc_hi), .b(mcand), .cin(1'b0), .sum(sum), .cout(cout));
  // next partial product: add mcand when the current multiplier bit is set, then shift right by one
  always_comb begin
    nxt_hi = q[0] ? {cout, sum[N-1:1]} : {1'b0, acc_hi[N-1:1]};
    nxt_q  = {q[0] ? sum[0] : acc_hi[0], q[N-1:1]};
    last   = cnt == CW'(N - 1);
  end
  // IDLE/RUN/DONE sequencer with registered product and done pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      mcand   <= '0;
      acc_hi  <= '0;
      q       <= '0;
      cnt     <= '0;
      product <= '0;
      done    <= 1'b0;
    end else begin
      done <= state == RUN && last;
      case (state)
        IDLE: if (bus.start) begin
          state  <= RUN;
          mcand  <= bus.a;
          acc_hi <= '0;
          q      <= bus.b;
          cnt    <= '0;
        end
        RUN: begin
          acc_hi <= nxt_hi;
          q      <= nxt_q;
          cnt    <= cnt + CW'(1);
          if (last) begin
            state   <= DONE;
            product <= {nxt_hi, nxt_q};
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign bus.in_ready = state == IDLE;
  assign bus.busy     = state != IDLE;
  assign bus.done     = done;
  assign bus.product  = product;
endmodule

// File: tb/tb_shift_add_mult.sv
// tb_shift_add_mult: directed and random checks of the shift-and-add multiplier at N=8 and N=16
module tb_shift_add_mult;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int done_n8 = 0;
  int cout_n8 = 0;
  int last_acc = 0;
  int prev_acc = 0;
  shift_add_mult_if #(.N(8)) i8();
  shift_add_mult_if #(.N(16)) i16();
  shift_add_mult #(.N(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(i8));
  shift_add_mult #(.N(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(i16));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (i8.done) done_n8 <= done_n8 + 1;
    if (i8.busy && !i8.done && dut8.q[0] && dut8.cout) cout_n8 <= cout_n8 + 1;
    if (i8.start && i8.in_ready) begin
      prev_acc <= last_acc;
      last_acc <= cyc;
    end
  end

  task automatic op8(input logic [7:0] x, input logic [7:0] y, output logic [15:0] p, output int lat);
    @(negedge clk);
    i8.a = x;
    i8.b = y;
    i8.start = 1'b1;
    @(negedge clk);
    i8.start = 1'b0;
    lat = 0;
    while (!i8.done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    p = i8.product;
  endtask

  task automatic test_reset;
    logic [15:0] p;
    int lat;
    op8(8'd2, 8'd3, p, lat);
    n_cmp++;
    if (p !== 16'h0006) begin n_err++; $display("FAIL reset_pre_op product=%h expected=0006", p); end
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({i8.in_ready, i8.busy, i8.done} !== 3'b100 || i8.product !== 16'h0000) begin
      n_err++;
      $display("FAIL reset_idle rdy/busy/done=%b product=%h expected=100 0000", {i8.in_ready, i8.busy, i8.done}, i8.product);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    logic [15:0] p;
    int lat;
    op8(8'd13, 8'd11, p, lat);
    n_cmp++;
    if (p !== 16'h008F || lat !== 8) begin n_err++; $display("FAIL basic_13x11 product=%h lat=%0d expected=008F lat=8", p, lat); end
    n_cmp++;
    if (i8.busy !== 1'b1) begin n_err++; $display("FAIL basic_busy_in_done got=%b expected=1", i8.busy); end
    op8(8'h00, 8'hA5, p, lat);
    n_cmp++;
    if (p !== 16'h0000) begin n_err++; $display("FAIL basic_0xA5 product=%h expected=0000", p); end
    op8(8'hFF, 8'h01, p, lat);
    n_cmp++;
    if (p !== 16'h00FF) begin n_err++; $display("FAIL basic_FFx01 product=%h expected=00FF", p); end
  endtask

  task automatic test_carry;
    logic [15:0] p;
    int lat;
    int c0;
    @(negedge clk);
    c0 = cout_n8;
    op8(8'hFF, 8'hFF, p, lat);
    n_cmp++;
    if (p !== 16'hFE01) begin n_err++; $display("FAIL carry_FFxFF product=%h expected=FE01", p); end
    n_cmp++;
    if (cout_n8 - c0 !== 7) begin n_err++; $display("FAIL carry_cout_iters got=%0d expected=7", cout_n8 - c0); end
  endtask

  task automatic test_back_to_back;
    int lat = 0;
    int hold_err = 0;
    @(negedge clk);
    i8.a = 8'd3;
    i8.b = 8'd5;
    i8.start = 1'b1;
    @(negedge clk);
    i8.a = 8'd200;
    i8.b = 8'd200;
    while (!i8.done && lat < 40) begin @(negedge clk); lat++; end
    n_cmp++;
    if (i8.product !== 16'h000F) begin n_err++; $display("FAIL b2b_first product=%h expected=000F", i8.product); end
    @(negedge clk);
    lat = 0;
    while (!i8.done && lat < 40) begin
      if (i8.product !== 16'h000F) hold_err++;
      @(negedge clk);
      lat++;
    end
    i8.start = 1'b0;
    n_cmp++;
    if (hold_err !== 0) begin n_err++; $display("FAIL b2b_hold changes=%0d expected=0", hold_err); end
    n_cmp++;
    if (i8.product !== 16'h9C40) begin n_err++; $display("FAIL b2b_second product=%h expected=9C40", i8.product); end
    n_cmp++;
    if (last_acc - prev_acc !== 10) begin n_err++; $display("FAIL b2b_spacing got=%0d expected=10", last_acc - prev_acc); end
    @(negedge clk);
  endtask

  task automatic test_ignored_start;
    int lat = 0;
    int d0;
    d0 = done_n8;
    @(negedge clk);
    i8.a = 8'd6;
    i8.b = 8'd7;
    i8.start = 1'b1;
    @(negedge clk);
    i8.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    i8.start = 1'b1;
    i8.a = 8'hFF;
    i8.b = 8'hFF;
    @(negedge clk);
    i8.start = 1'b0;
    while (!i8.done && lat < 40) begin @(negedge clk); lat++; end
    i8.start = 1'b1;
    i8.a = 8'h11;
    @(negedge clk);
    i8.start = 1'b0;
    n_cmp++;
    if (i8.product !== 16'h002A) begin n_err++; $display("FAIL ignored_product product=%h expected=002A", i8.product); end
    repeat (12) @(negedge clk);
    n_cmp++;
    if (done_n8 - d0 !== 1 || i8.busy !== 1'b0) begin
      n_err++;
      $display("FAIL ignored_no_extra dones=%0d busy=%b expected=1 0", done_n8 - d0, i8.busy);
    end
  endtask

  task automatic test_reset_mid;
    logic [15:0] p;
    int lat;
    int d0;
    d0 = done_n8;
    @(negedge clk);
    i8.a = 8'hAB;
    i8.b = 8'hCD;
    i8.start = 1'b1;
    @(negedge clk);
    i8.start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    n_cmp++;
    if (done_n8 !== d0 || i8.product !== 16'h0000 || i8.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_mid dones=%0d product=%h ready=%b expected=0 0000 1", done_n8 - d0, i8.product, i8.in_ready);
    end
    op8(8'd7, 8'd9, p, lat);
    n_cmp++;
    if (p !== 16'h003F) begin n_err++; $display("FAIL reset_mid_next product=%h expected=003F", p); end
  endtask

  task automatic test_random;
    logic [7:0] x8, y8;
    logic [15:0] x16, y16;
    logic [15:0] e8;
    logic [31:0] e16;
    logic [15:0] g8;
    logic [31:0] g16;
    logic s8, s16;
    int w;
    for (int k = 0; k < 1000; k++) begin
      x8 = 8'($urandom);
      y8 = 8'($urandom);
      x16 = 16'($urandom);
      y16 = 16'($urandom);
      e8 = 16'(x8) * 16'(y8);
      e16 = 32'(x16) * 32'(y16);
      @(negedge clk);
      i8.a = x8;
      i8.b = y8;
      i16.a = x16;
      i16.b = y16;
      i8.start = 1'b1;
      i16.start = 1'b1;
      @(negedge clk);
      i8.start = 1'b0;
      i16.start = 1'b0;
      s8 = 1'b0;
      s16 = 1'b0;
      g8 = 'x;
      g16 = 'x;
      w = 0;
      while (!(s8 && s16) && w < 40) begin
        if (i8.done && !s8) begin s8 = 1'b1; g8 = i8.product; end
        if (i16.done && !s16) begin s16 = 1'b1; g16 = i16.product; end
        @(negedge clk);
        w++;
      end
      n_cmp++;
      if (g8 !== e8) begin n_err++; $display("FAIL rand8 %0d*%0d got=%h expected=%h", x8, y8, g8, e8); end
      n_cmp++;
      if (g16 !== e16) begin n_err++; $display("FAIL rand16 %0d*%0d got=%h expected=%h", x16, y16, g16, e16); end
      while (!(i8.in_ready && i16.in_ready) && w < 60) begin @(negedge clk); w++; end
    end
  endtask

  initial begin
    i8.start = 1'b0;
    i8.a = '0;
    i8.b = '0;
    i16.start = 1'b0;
    i16.a = '0;
    i16.b = '0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({i8.in_ready, i8.busy, i8.done} !== 3'b100 || i8.product !== 16'h0000) begin
      n_err++;
      $display("FAIL power_on_reset rdy/busy/done=%b product=%h expected=100 0000", {i8.in_ready, i8.busy, i8.done}, i8.product);
    end
    rst_n = 1'b1;
    test_reset;
    test_basic;
    test_carry;
    test_back_to_back;
    test_ignored_start;
    test_reset_mid;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
